// File: rtl/v_slide_seq_if.sv
// Request/beat bundle between issue, the slide sequencer and the register-file write port.
// The slave modport is the sequencer's view; master is the issue/regfile side.
interface v_slide_seq_if #(
    parameter int VLEN     = 128,
    parameter int MAX_LMUL = 4
);
    localparam int GW  = VLEN * MAX_LMUL;
    localparam int VLW = $clog2(GW / 8) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op;
    logic [1:0]        sew;
    logic [1:0]        lmul;
    logic [VLW-1:0]    vl;
    logic [31:0]       offset;
    logic [31:0]       scalar;
    logic              vm;
    logic [GW/8-1:0]   mask;
    logic [GW-1:0]     vs2_data;
    logic [GW-1:0]     vd_old;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_beat;
    logic [VLEN-1:0]   out_data;
    logic              out_last;
    logic              illegal;

    modport slave (
        input  in_valid, op, sew, lmul, vl, offset, scalar, vm, mask, vs2_data, vd_old, out_ready,
        output in_ready, out_valid, out_beat, out_data, out_last, illegal
    );

    modport master (
        output in_valid, op, sew, lmul, vl, offset, scalar, vm, mask, vs2_data, vd_old, out_ready,
        input  in_ready, out_valid, out_beat, out_data, out_last, illegal
    );
endinterface

// File: rtl/v_slide_seq.sv
// Multi-beat vector slide/move sequencer: captures one request, then emits one
// VLEN-bit destination register per beat with tail-undisturbed and v0-mask handling.
module v_slide_seq #(
    parameter int VLEN     = 128,
    parameter int MAX_LMUL = 4
) (
    input  logic         clk,
    input  logic         rst,
    v_slide_seq_if.slave bus
);
    localparam int GW  = VLEN * MAX_LMUL;
    localparam int VLW = $clog2(GW / 8) + 1;
    localparam int MW  = $clog2(GW / 8);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_VMV    = 3'd0;
    localparam logic [2:0] OP_UP     = 3'd1;
    localparam logic [2:0] OP_1UP    = 3'd2;
    localparam logic [2:0] OP_DOWN   = 3'd3;
    localparam logic [2:0] OP_1DOWN  = 3'd4;

    logic [0:0]      state_q, state_d;
    logic [2:0]      beat_q, beat_d;
    logic [3:0]      nreg_q;
    logic [2:0]      op_q;
    logic [1:0]      sew_q;
    logic [VLW-1:0]  vl_q;
    logic [31:0]     offset_q;
    logic [31:0]     scalar_q;
    logic            vm_q;
    logic [GW/8-1:0] mask_q;
    logic [GW-1:0]   vs2_q;
    logic [GW-1:0]   vd_q;
    logic            bad_q;
    logic            illegal_q;

    logic            accept;
    logic            lmul_big;
    logic            req_bad;
    logic            last;
    logic [VLEN-1:0] data_mux;

    assign accept   = (state_q == S_IDLE) && bus.in_valid;
    assign lmul_big = (4'd1 << bus.lmul) > 4'(MAX_LMUL);
    assign req_bad  = (bus.op > OP_1DOWN) || (bus.sew == 2'd3) || lmul_big;
    assign last     = ({1'b0, beat_q} == (nreg_q - 4'd1));

    // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d = S_RUN;
                    beat_d  = 3'd0;
                end
            end
            S_RUN: begin
                if (bus.out_ready) begin
                    if (last) begin
                        state_d = S_IDLE;
                        beat_d  = 3'd0;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: the wide operand registers are cleared on reset too, so the idle bus never shows a stale group.
        if (rst) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            nreg_q    <= '0;
            op_q      <= '0;
            sew_q     <= '0;
            vl_q      <= '0;
            offset_q  <= '0;
            scalar_q  <= '0;
            vm_q      <= 1'b0;
            mask_q    <= '0;
            vs2_q     <= '0;
            vd_q      <= '0;
            bad_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            illegal_q <= accept && req_bad;
            if (accept) begin
                nreg_q   <= lmul_big ? 4'(MAX_LMUL) : (4'd1 << bus.lmul);
                op_q     <= bus.op;
                sew_q    <= bus.sew;
                vl_q     <= bus.vl;
                offset_q <= bus.offset;
                scalar_q <= bus.scalar;
                vm_q     <= bus.vm;
                mask_q   <= bus.mask;
                vs2_q    <= bus.vs2_data;
                vd_q     <= bus.vd_old;
                bad_q    <= req_bad;
            end
        end
    end

    // One result lane per element width; sew selects which one drives the beat.
    for (genvar w = 0; w < 3; w++) begin : g_ew
        localparam int EW = 8 << w;
        localparam int NE = VLEN / EW;
        localparam int GE = GW / EW;
        localparam int IW = $clog2(GE);

        logic [EW-1:0]   vs2_e [GE];
        logic [EW-1:0]   old_e [GE];
        logic [VLEN-1:0] res;

        for (genvar k = 0; k < GE; k++) begin : g_split
            assign vs2_e[k] = vs2_q[k*EW +: EW];
            assign old_e[k] = vd_q[k*EW +: EW];
        end

        always_comb begin
            logic [31:0]   vlmax;
            logic [31:0]   vle;
            logic [31:0]   idx;
            logic [32:0]   src;
            logic [IW-1:0] ix;
            logic [EW-1:0] e;
            vlmax = 32'(nreg_q) * 32'(NE);
            vle   = (32'(vl_q) < vlmax) ? 32'(vl_q) : vlmax;
            idx   = '0;
            src   = '0;
            ix    = '0;
            e     = '0;
            res   = '0;
            for (int j = 0; j < NE; j++) begin
                idx = 32'(beat_q) * 32'(NE) + 32'(j);
                ix  = IW'(idx);
                e   = old_e[ix];
                if (!bad_q && (idx < vle) && (vm_q || mask_q[MW'(idx)])) begin
                    case (op_q)
                        OP_VMV:   e = vs2_e[ix];
                        OP_UP:    if (idx >= offset_q) e = vs2_e[IW'(idx - offset_q)];
                        OP_1UP:   e = (idx == 32'd0) ? scalar_q[EW-1:0] : vs2_e[IW'(idx - 32'd1)];
                        OP_DOWN: begin
                            // 33-bit sum so a huge offset can never wrap back into the group.
                            src = {1'b0, offset_q} + {1'b0, idx};
                            e   = (src < {1'b0, vlmax}) ? vs2_e[IW'(src)] : '0;
                        end
                        OP_1DOWN: e = (idx == vle - 32'd1) ? scalar_q[EW-1:0] : vs2_e[IW'(idx + 32'd1)];
                        default:  e = old_e[ix];
                    endcase
                end
                res[j*EW +: EW] = e;
            end
        end
    end

    always_comb begin
        case (sew_q)
            2'd0:    data_mux = g_ew[0].res;
            2'd1:    data_mux = g_ew[1].res;
            default: data_mux = g_ew[2].res;
        endcase
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_RUN);
    assign bus.out_beat  = beat_q;
    assign bus.out_last  = (state_q == S_RUN) && last;
    assign bus.out_data  = (state_q == S_RUN) ? data_mux : '0;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_v_slide_seq.sv
// Directed bench for v_slide_seq: slides, masking, tail handling, backpressure,
// reset during an operation and illegal requests, all against hand-computed beats.
module tb_v_slide_seq;
    localparam int VLEN     = 128;
    localparam int MAX_LMUL = 4;
    localparam int GW       = VLEN * MAX_LMUL;
    localparam int VLW      = $clog2(GW / 8) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [GW-1:0] vs2_w;
    logic [GW-1:0] old_w;
    logic [GW-1:0] bytes_w;

    v_slide_seq_if #(.VLEN(VLEN), .MAX_LMUL(MAX_LMUL)) bus ();

    v_slide_seq #(.VLEN(VLEN), .MAX_LMUL(MAX_LMUL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] e4(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic issue(input logic [2:0] op_v, input logic [1:0] sew_v, input logic [1:0] lmul_v,
                         input logic [VLW-1:0] vl_v, input logic [31:0] off_v, input logic [31:0] scal_v,
                         input logic vm_v, input logic [GW/8-1:0] mask_v, input logic [GW-1:0] src_v);
        @(negedge clk);
        bus.op       = op_v;
        bus.sew      = sew_v;
        bus.lmul     = lmul_v;
        bus.vl       = vl_v;
        bus.offset   = off_v;
        bus.scalar   = scal_v;
        bus.vm       = vm_v;
        bus.mask     = mask_v;
        bus.vs2_data = src_v;
        bus.vd_old   = old_w;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.out_beat, bus.out_last, bus.illegal} !== 7'b1000000
            || bus.out_data !== '0) begin
            n_bad++;
            $display("FAIL reset: got rdy=%0b v=%0b b=%0d l=%0b ill=%0b d=%h, want rdy=1 v=0 b=0 l=0 ill=0 d=0",
                     bus.in_ready, bus.out_valid, bus.out_beat, bus.out_last, bus.illegal, bus.out_data);
        end
    endtask

    // Two beats back to back, then exactly one idle bubble.
    task automatic test_slideup();
        logic [127:0] exp [2];
        exp[0] = e4(32'hA0, 32'hA1, 32'hA2, 32'h10);
        exp[1] = e4(32'h11, 32'h12, 32'h13, 32'h14);
        bus.out_ready = 1'b1;
        issue(3'd1, 2'd2, 2'd1, 8, 32'd3, 32'd0, 1'b1, '0, vs2_w);
        n_cmp++;
        if (bus.illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL slideup illegal: got %0b want 0", bus.illegal);
        end
        for (int b = 0; b < 2; b++) begin
            n_cmp++;
            if ({bus.out_valid, bus.out_beat, bus.out_last, bus.out_data} !== {1'b1, 3'(b), (b == 1), exp[b]}) begin
                n_bad++;
                $display("FAIL slideup beat%0d: got v=%0b b=%0d l=%0b d=%h, want l=%0b d=%h",
                         b, bus.out_valid, bus.out_beat, bus.out_last, bus.out_data, (b == 1), exp[b]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL slideup bubble: got v=%0b rdy=%0b want v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_slide1down();
        logic [127:0] exp [2];
        exp[0] = e4(32'h11, 32'h12, 32'h13, 32'h14);
        exp[1] = e4(32'h15, 32'h98765432, 32'hA6, 32'hA7);
        bus.out_ready = 1'b1;
        issue(3'd4, 2'd2, 2'd1, 6, 32'd0, 32'h98765432, 1'b1, '0, vs2_w);
        for (int b = 0; b < 2; b++) begin
            n_cmp++;
            if ({bus.out_valid, bus.out_beat, bus.out_last, bus.out_data} !== {1'b1, 3'(b), (b == 1), exp[b]}) begin
                n_bad++;
                $display("FAIL slide1down beat%0d: got v=%0b b=%0d l=%0b d=%h, want d=%h",
                         b, bus.out_valid, bus.out_beat, bus.out_last, bus.out_data, exp[b]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_slidedown();
        logic [127:0] exp [4];
        logic [31:0]  offs [2];
        offs[0] = 32'd5;
        offs[1] = 32'hFFFF_FFFF;
        exp[0]  = e4(32'h15, 32'h16, 32'h17, 32'h0);
        exp[1]  = '0;
        exp[2]  = '0;
        exp[3]  = '0;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            issue(3'd3, 2'd2, 2'd1, 8, offs[t], 32'd0, 1'b1, '0, vs2_w);
            for (int b = 0; b < 2; b++) begin
                n_cmp++;
                if ({bus.out_valid, bus.out_beat, bus.out_last, bus.out_data} !== {1'b1, 3'(b), (b == 1), exp[2*t+b]}) begin
                    n_bad++;
                    $display("FAIL slidedown off=%h beat%0d: got v=%0b b=%0d l=%0b d=%h, want d=%h",
                             offs[t], b, bus.out_valid, bus.out_beat, bus.out_last, bus.out_data, exp[2*t+b]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_slide1up_e8();
        logic [127:0] exp;
        for (int k = 0; k < 16; k++) exp[k*8 +: 8] = (k == 0) ? 8'h32 : 8'(k - 1);
        bus.out_ready = 1'b1;
        issue(3'd2, 2'd0, 2'd0, 16, 32'd0, 32'h98765432, 1'b1, '0, bytes_w);
        n_cmp++;
        if ({bus.out_valid, bus.out_beat, bus.out_last, bus.out_data} !== {1'b1, 3'd0, 1'b1, exp}) begin
            n_bad++;
            $display("FAIL slide1up_e8: got v=%0b b=%0d l=%0b d=%h, want v=1 b=0 l=1 d=%h",
                     bus.out_valid, bus.out_beat, bus.out_last, bus.out_data, exp);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL slide1up_e8 single beat: got v=%0b want 0", bus.out_valid);
        end
    endtask

    task automatic test_masked();
        logic [127:0] exp [2];
        exp[0] = e4(32'hA0, 32'h10, 32'hA2, 32'h12);
        exp[1] = e4(32'hA4, 32'h14, 32'hA6, 32'h16);
        bus.out_ready = 1'b1;
        issue(3'd1, 2'd2, 2'd1, 8, 32'd1, 32'd0, 1'b0, 64'hAA, vs2_w);
        for (int b = 0; b < 2; b++) begin
            n_cmp++;
            if ({bus.out_valid, bus.out_beat, bus.out_last, bus.out_data} !== {1'b1, 3'(b), (b == 1), exp[b]}) begin
                n_bad++;
                $display("FAIL masked beat%0d: got v=%0b b=%0d l=%0b d=%h, want d=%h",
                         b, bus.out_valid, bus.out_beat, bus.out_last, bus.out_data, exp[b]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_vl_zero();
        logic [127:0] exp [2];
        exp[0] = e4(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        exp[1] = e4(32'hA4, 32'hA5, 32'hA6, 32'hA7);
        bus.out_ready = 1'b1;
        issue(3'd0, 2'd2, 2'd1, 0, 32'd0, 32'd0, 1'b1, '0, vs2_w);
        for (int b = 0; b < 2; b++) begin
            n_cmp++;
            if ({bus.out_valid, bus.out_beat, bus.out_last, bus.out_data} !== {1'b1, 3'(b), (b == 1), exp[b]}) begin
                n_bad++;
                $display("FAIL vl_zero beat%0d: got v=%0b b=%0d l=%0b d=%h, want d=%h",
                         b, bus.out_valid, bus.out_beat, bus.out_last, bus.out_data, exp[b]);
            end
            @(negedge clk);
        end
    endtask

    // Stalled beat must hold; a request arriving meanwhile is ignored.
    task automatic test_backpressure();
        logic [127:0] exp0;
        logic [127:0] exp1;
        exp0 = e4(32'h10, 32'h11, 32'h12, 32'h13);
        exp1 = e4(32'h14, 32'h15, 32'h16, 32'h17);
        bus.out_ready = 1'b0;
        issue(3'd0, 2'd2, 2'd1, 8, 32'd0, 32'd0, 1'b1, '0, vs2_w);
        bus.op       = 3'd3;
        bus.offset   = 32'd2;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if ({bus.out_valid, bus.in_ready, bus.out_beat, bus.out_last, bus.out_data} !== {2'b10, 3'd0, 1'b0, exp0}) begin
                n_bad++;
                $display("FAIL backpressure cycle%0d: got v=%0b rdy=%0b b=%0d l=%0b d=%h, want v=1 rdy=0 b=0 l=0 d=%h",
                         c, bus.out_valid, bus.in_ready, bus.out_beat, bus.out_last, bus.out_data, exp0);
            end
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_cmp++;
        if ({bus.out_valid, bus.out_beat, bus.out_data} !== {1'b1, 3'd0, exp0}) begin
            n_bad++;
            $display("FAIL backpressure release: got v=%0b b=%0d d=%h, want v=1 b=0 d=%h",
                     bus.out_valid, bus.out_beat, bus.out_data, exp0);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.out_valid, bus.out_beat, bus.out_last, bus.out_data} !== {1'b1, 3'd1, 1'b1, exp1}) begin
            n_bad++;
            $display("FAIL backpressure beat1: got v=%0b b=%0d l=%0b d=%h, want v=1 b=1 l=1 d=%h",
                     bus.out_valid, bus.out_beat, bus.out_last, bus.out_data, exp1);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_in_run();
        bus.out_ready = 1'b1;
        issue(3'd0, 2'd2, 2'd1, 8, 32'd0, 32'd0, 1'b1, '0, vs2_w);
        @(negedge clk);
        n_cmp++;
        if ({bus.out_valid, bus.out_beat} !== {1'b1, 3'd1}) begin
            n_bad++;
            $display("FAIL rst_in_run pre: got v=%0b b=%0d want v=1 b=1", bus.out_valid, bus.out_beat);
        end
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if ({bus.out_valid, bus.in_ready, bus.out_beat, bus.out_last, bus.illegal} !== 7'b0100000
                || bus.out_data !== '0) begin
                n_bad++;
                $display("FAIL rst_in_run cycle%0d: got v=%0b rdy=%0b b=%0d l=%0b d=%h, want v=0 rdy=1 b=0 l=0 d=0",
                         c, bus.out_valid, bus.in_ready, bus.out_beat, bus.out_last, bus.out_data);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        logic [127:0] exp [4];
        logic [2:0]   ops [2];
        logic [1:0]   lmuls [2];
        int           nb [2];
        exp[0] = e4(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        exp[1] = e4(32'hA4, 32'hA5, 32'hA6, 32'hA7);
        exp[2] = e4(32'hA8, 32'hA9, 32'hAA, 32'hAB);
        exp[3] = e4(32'hAC, 32'hAD, 32'hAE, 32'hAF);
        ops[0] = 3'd6;  lmuls[0] = 2'd1;  nb[0] = 2;
        ops[1] = 3'd0;  lmuls[1] = 2'd3;  nb[1] = 4;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            issue(ops[t], 2'd2, lmuls[t], 64, 32'd0, 32'd0, 1'b1, '0, vs2_w);
            for (int b = 0; b < nb[t]; b++) begin
                n_cmp++;
                if ({bus.illegal, bus.out_valid, bus.out_beat, bus.out_last, bus.out_data}
                    !== {(b == 0), 1'b1, 3'(b), (b == nb[t] - 1), exp[b]}) begin
                    n_bad++;
                    $display("FAIL illegal t%0d beat%0d: got ill=%0b v=%0b b=%0d l=%0b d=%h, want ill=%0b l=%0b d=%h",
                             t, b, bus.illegal, bus.out_valid, bus.out_beat, bus.out_last, bus.out_data,
                             (b == 0), (b == nb[t] - 1), exp[b]);
                end
                @(negedge clk);
            end
            n_cmp++;
            if (bus.out_valid !== 1'b0 || bus.illegal !== 1'b0) begin
                n_bad++;
                $display("FAIL illegal t%0d end: got v=%0b ill=%0b want v=0 ill=0", t, bus.out_valid, bus.illegal);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < GW / 32; i++) begin
            vs2_w[i*32 +: 32] = 32'h10 + 32'(i);
            old_w[i*32 +: 32] = 32'hA0 + 32'(i);
        end
        for (int i = 0; i < GW / 8; i++) bytes_w[i*8 +: 8] = 8'(i);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = '0;
        bus.sew       = '0;
        bus.lmul      = '0;
        bus.vl        = '0;
        bus.offset    = '0;
        bus.scalar    = '0;
        bus.vm        = 1'b1;
        bus.mask      = '0;
        bus.vs2_data  = '0;
        bus.vd_old    = '0;

        test_reset();
        test_slideup();
        test_slide1down();
        test_slidedown();
        test_slide1up_e8();
        test_masked();
        test_vl_zero();
        test_backpressure();
        test_rst_in_run();
        test_illegal();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/v_slide_seq.md
Name: v_slide_seq

Overview:
- Parametrised, multi-beat successor to the vector slide/move unit (SLDU) of the integrated coprocessor.
- Supports selectable SEW (8/16/32), register-group LMUL up to MAX_LMUL, vl-bounded bodies, tail-undisturbed and v0-mask handling.
- Produces one VLEN-bit destination register per beat under a valid/ready handshake into the register-file write port.
- Sits between the decoder/issue stage and the vector register file.

Parameters:
- VLEN, 128, bits per vector register.
- MAX_LMUL, 4, max registers per group (power of 2, 1..8).
- GW, VLEN*MAX_LMUL, derived group width in bits.
- VLW, $clog2(GW/8)+1, derived vl width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- op  in  3  0=VMV, 1=VSLIDEUP, 2=VSLIDE1UP, 3=VSLIDEDOWN, 4=VSLIDE1DOWN, 5-7 reserved.
- sew  in  2  0=8b, 1=16b, 2=32b, 3 reserved.
- lmul  in  2  group size 1<<lmul registers.
- vl  in  VLW  active element count.
- offset  in  32  slide amount, unsigned (x-reg or zero-extended imm).
- scalar  in  32  slide1 insert value, low SEW bits used.
- vm  in  1  1=unmasked, 0=use mask.
- mask  in  GW/8  v0 bits, bit i governs element i.
- vs2_data  in  GW  source group, element i at bits [i*SEW +: SEW].
- vd_old  in  GW  current destination group contents.
- out_valid  out  1  beat valid.
- out_ready  in  1  regfile accepts beat.
- out_beat  out  3  register index within group (vd+out_beat).
- out_data  out  VLEN  destination register data.
- out_last  out  1  final beat of the operation.
- illegal  out  1  one-cycle pulse at accept for a reserved op, sew=3, or (1<<lmul)>MAX_LMUL.

Behaviour:
- Reset values: in_ready=1; out_valid=0, out_beat=0, out_data=0, out_last=0, illegal=0. All captured operands are cleared.
- FSM states are IDLE and RUN.
- IDLE: in_ready=1. On in_valid, capture all inputs into registers, set beat=0, go to RUN.
- RUN: in_ready=0, out_valid=1. On out_ready, if beat==NREG-1 go to IDLE, else increment beat.
- out_last=1 when beat==NREG-1.
- Latency: first beat is valid the cycle after accept. Sustained rate is 1 beat/cycle with out_ready held high. There is one IDLE bubble between operations.
- Backpressure: while out_valid && !out_ready, out_data, out_beat and out_last must hold stable.
- Derived values: NREG=1<<lmul (clamped to MAX_LMUL when illegal); E=VLEN/SEW; VLMAX=NREG*E; vle=min(vl,VLMAX).
- Element i (0..VLMAX-1) result:
  - i>=vle (tail): vd_old[i].
  - vm=0 && mask[i]=0: vd_old[i].
  - VMV: vs2[i].
  - VSLIDEUP: i<offset gives vd_old[i], else vs2[i-offset]. offset>=VLMAX leaves the whole body old. Compare at 32 bits with no truncation.
  - VSLIDE1UP: i==0 gives scalar[SEW-1:0], else vs2[i-1].
  - VSLIDEDOWN: src=i+offset, computed at 33 bits. src<VLMAX gives vs2[src], else 0.
  - VSLIDE1DOWN: i==vle-1 gives scalar[SEW-1:0], else vs2[i+1].
- vl=0: all beats equal vd_old registers; the operation still emits NREG beats.
- Illegal request: accepted, illegal pulses, beats carry vd_old unchanged. Element width for an illegal sew is 32.
- rst in RUN: next cycle IDLE with outputs at reset values; the pending operation is discarded and no further beats are emitted.
- in_valid while in RUN is ignored (in_ready=0).

Test Plan:
Common setup: VLEN=128, MAX_LMUL=4, sew=2, lmul=1 (VLMAX=8), vs2 elem i=0x10+i, vd_old elem i=0xA0+i, vm=1 unless stated.
1. VSLIDEUP offset=3, vl=8 -> beat0 elems {A0,A1,A2,10}, beat1 {11,12,13,14}; out_last on beat1; 2 beats on consecutive cycles.
2. VSLIDE1DOWN scalar=0x98765432, vl=6 -> elems {11,12,13,14,15,98765432,A6,A7}.
3. VSLIDEDOWN offset=5, vl=8 -> {15,16,17,0,0,0,0,0}. Same with offset=0xFFFFFFFF -> all 0, no wrap.
4. sew=0, lmul=0, vs2 byte i=i, VSLIDE1UP scalar=0x98765432, vl=16 -> out_data bytes {32,00,01,...,0E}, single beat, out_last=1.
5. VSLIDEUP offset=1, vm=0, mask=0xAA -> {A0,10,A2,12,A4,14,A6,16}.
6. Handshakes:
   - Hold out_ready=0 for 3 cycles at beat0 -> out_data/out_beat stable, in_ready=0.
   - Assert rst during beat1 -> next cycle out_valid=0, in_ready=1.
   - op=6 -> illegal pulse, beats equal vd_old.
